// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the load/store unit: FSM states, funct3 codes
// and the classification of faulting requests.
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    typedef enum logic [1:0] {
        FC_NONE,
        FC_RW_BOTH,
        FC_FUNCT3,
        FC_MISALIGN
    } fault_cause_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic fault_cause_e fault_cause(input logic       rd,
                                                 input logic       wr,
                                                 input logic [2:0] f3,
                                                 input logic [1:0] lo);
        fault_cause_e c;
        c = FC_NONE;
        if (rd && wr)
            c = FC_RW_BOTH;
        else if (rd && !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU}))
            c = FC_FUNCT3;
        else if (wr && !(f3 inside {F3_B, F3_H, F3_W}))
            c = FC_FUNCT3;
        else if ((rd || wr) && ((f3[1:0] == 2'b01 && lo[0]) ||
                                (f3[1:0] == 2'b10 && lo != 2'b00)))
            c = FC_MISALIGN;
        return c;
    endfunction

endpackage

// File: rtl/mem_byte_ram.sv
// Single-port synchronous word RAM with per-byte write enables and a
// registered read port that only updates when a read is issued.
module mem_byte_ram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (we && be[i])
                mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
        if (re)
            rdata_q <= mem[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: accepts one request at a time, writes stores on the
// acceptance edge, and returns extended load data after READ_LATENCY cycles.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int DEPTH_WORDS  = 1024,
    parameter int READ_LATENCY = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [2:0]      req_funct3,
    input  logic            req_read,
    input  logic            req_write,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_fault,
    output logic            busy
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_e       state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [2:0]   f3_q, f3_d;
    logic [1:0]   off_q, off_d;
    logic         load_q, load_d;
    logic         fault_q, fault_d;

    fault_cause_e cause;
    logic         accept, req_fault, legal_load, legal_store;
    logic [3:0]   be;
    logic [31:0]  wlanes, ram_rdata, load_data;
    logic [7:0]   sel_byte;
    logic [15:0]  sel_half;
    logic         unused_addr_bits;

    assign accept      = req_valid && (state_q == ST_IDLE);
    assign cause       = fault_cause(req_read, req_write, req_funct3, req_addr[1:0]);
    assign req_fault   = (cause != FC_NONE);
    assign legal_load  = req_read && !req_fault;
    assign legal_store = req_write && !req_fault;
    assign unused_addr_bits = ^req_addr[XLEN-1:AW+2];

    always_comb begin
        be     = 4'b1111;
        wlanes = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                be     = 4'b0001 << req_addr[1:0];
                wlanes = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be     = req_addr[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    mem_byte_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_ram (
        .clk  (clk),
        .we   (accept && legal_store),
        .be   (be),
        .re   (accept && legal_load),
        .addr (req_addr[AW+1:2]),
        .wdata(wlanes),
        .rdata(ram_rdata)
    );

    assign sel_byte = ram_rdata[{off_q, 3'b000} +: 8];
    assign sel_half = off_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];

    always_comb begin
        case (f3_q)
            F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
            F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
            F3_BU:   load_data = {24'd0, sel_byte};
            F3_HU:   load_data = {16'd0, sel_half};
            default: load_data = ram_rdata;
        endcase
    end

    // The final WAIT cycle (counter at zero) already presents the response, so
    // READ_LATENCY=1 needs no extra cycle; an unaccepted response parks in RESP.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        f3_d       = f3_q;
        off_d      = off_q;
        load_d     = load_q;
        fault_d    = fault_q;
        resp_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    f3_d    = req_funct3;
                    off_d   = req_addr[1:0];
                    load_d  = legal_load;
                    fault_d = req_fault;
                    if (legal_load) begin
                        state_d = ST_WAIT;
                        cnt_d   = 2'(READ_LATENCY - 1);
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 2'd0) begin
                    resp_valid = 1'b1;
                    state_d    = resp_ready ? ST_IDLE : ST_RESP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            f3_q    <= '0;
            off_q   <= '0;
            load_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            load_q  <= load_d;
            fault_q <= fault_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign resp_rdata = (resp_valid && load_q) ? load_data : '0;
    assign resp_fault = resp_valid && fault_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized scoreboard bench for mem_access_unit against a byte-array
// reference model of the memory and the load/store rules.
module tb_mem_access_unit;

    localparam int DEPTH = 1024;
    localparam int RL    = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_funct3;
    logic        req_read, req_write;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_fault, busy;

    always #5 clk = ~clk;

    mem_access_unit #(
        .XLEN        (32),
        .DEPTH_WORDS (DEPTH),
        .READ_LATENCY(RL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_funct3(req_funct3),
        .req_read  (req_read),
        .req_write (req_write),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .resp_fault(resp_fault),
        .busy      (busy)
    );

    typedef struct {
        logic [31:0] rdata;
        bit          fault;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic [7:0]  mm [DEPTH*4];
    bit          rr_force = 1'b0;
    bit          rr_val   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic finish_now();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    // Reference: memory as a flat byte array indexed modulo its byte size.
    function automatic void ref_model(input bit rd, input bit wr, input logic [2:0] f3,
                                      input logic [31:0] a, input logic [31:0] wd,
                                      output logic [31:0] r, output bit flt, output bit ldok);
        int     sz;
        int     base;
        longint v;
        sz  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        flt = 1'b0;
        if (rd && wr) flt = 1'b1;
        if (rd && !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5)) flt = 1'b1;
        if (wr && f3 > 2) flt = 1'b1;
        if ((rd || wr) && (a % sz) != 0) flt = 1'b1;
        ldok = rd && !flt;
        base = int'(a % (DEPTH * 4));
        r    = '0;
        if (ldok) begin
            v = 0;
            for (int k = 0; k < sz; k++) v = v | (longint'(mm[base+k]) << (8 * k));
            if (!f3[2] && sz < 4 && v[8*sz-1]) v = v - (longint'(1) << (8 * sz));
            r = v[31:0];
        end
        if (wr && !flt)
            for (int k = 0; k < sz; k++) mm[base+k] = 8'(wd >> (8 * k));
    endfunction

    task automatic issue(input bit rd, input bit wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input bit fixed, input logic [31:0] fixed_val, input bit fixed_fault);
        exp_t        e;
        logic [31:0] r;
        bit          flt, ldok;
        int          n;
        @(posedge clk); #1;
        n = 0;
        while (!req_ready) begin
            @(posedge clk); #1;
            n++;
            if (n > 200) begin
                checks++; failures++;
                $display("FAIL req_ready_timeout actual=0 required=1");
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $fatal(1, "timeout");
            end
        end
        req_valid  = 1'b1;
        req_read   = rd;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk); #1;
        ref_model(rd, wr, f3, a, wd, r, flt, ldok);
        e.rdata = fixed ? fixed_val : r;
        e.fault = fixed ? fixed_fault : flt;
        e.lat   = ldok ? RL : 1;
        e.acc   = cyc;
        sb.push_back(e);
        // Garbage on the request bus after acceptance must not matter.
        req_valid  = 1'b0;
        req_read   = 1'($urandom);
        req_write  = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 || !req_ready) begin
            @(posedge clk); #1;
            n++;
            if (n > 500) begin
                checks++; failures++;
                $display("FAIL drain_timeout actual=%0d required=0", sb.size());
                finish_now();
            end
        end
    endtask

    initial begin
        resp_ready = 1'b0;
        forever begin
            @(posedge clk); #2;
            resp_ready = rr_force ? rr_val : ($urandom_range(0, 9) < 7);
        end
    end

    // Monitor: pops the scoreboard on every response handshake.
    initial begin
        bit          trk;
        logic [31:0] hr;
        logic        hf;
        int          first;
        exp_t        e;
        trk = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                trk = 1'b0;
                continue;
            end
            check1("busy_vs_outstanding", {30'd0, busy, req_ready},
                   {30'd0, sb.size() != 0, sb.size() == 0});
            if (resp_valid) begin
                if (!trk) begin
                    trk = 1'b1; hr = resp_rdata; hf = resp_fault; first = cyc;
                end else begin
                    check1("resp_hold", {resp_rdata[30:0], resp_fault} ^ {hr[30:0], hf}, 32'd0);
                    check1("resp_hold_msb", {31'd0, resp_rdata[31]}, {31'd0, hr[31]});
                end
                if (resp_ready) begin
                    trk = 1'b0;
                    if (sb.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_resp actual=0x%08h required=none", resp_rdata);
                    end else begin
                        e = sb.pop_front();
                        check1("resp_rdata", resp_rdata, e.rdata);
                        check1("resp_fault", {31'd0, resp_fault}, {31'd0, e.fault});
                        check1("resp_latency", 32'(first - e.acc + 1), 32'(e.lat));
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        checks++; failures++;
        $display("FAIL watchdog actual=running required=done");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, wd;
        logic [2:0]  f3;
        bit          rd, wr;
        int          k;
        rst = 1'b1;
        req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
        req_funct3 = '0; req_addr = '0; req_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check1("rst_outputs", {27'd0, resp_valid, resp_fault, busy, req_ready, 1'b0}, 32'b00010);
        check1("rst_rdata", resp_rdata, 32'd0);
        @(negedge clk) rst = 1'b0;

        for (int w = 0; w < 16; w++) issue(0, 1, 3'b010, 32'(w * 4), $urandom, 0, 0, 0);

        issue(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 0, 0);
        issue(1, 0, 3'b010, 32'h10, 32'h0, 1, 32'hDEADBEEF, 0);

        issue(0, 1, 3'b000, 32'h13, 32'h80, 0, 0, 0);
        issue(1, 0, 3'b000, 32'h13, 32'h0, 1, 32'hFFFFFF80, 0);
        issue(1, 0, 3'b100, 32'h13, 32'h0, 1, 32'h00000080, 0);

        issue(1, 0, 3'b010, 32'h12, 32'h0, 1, 32'h0, 1);
        issue(0, 1, 3'b001, 32'h21, 32'h1234, 1, 32'h0, 1);
        issue(1, 0, 3'b010, 32'h20, 32'h0, 0, 0, 0);

        issue(0, 1, 3'b010, 32'h1004, 32'hCAFE0123, 0, 0, 0);
        issue(1, 0, 3'b010, 32'h0004, 32'h0, 1, 32'hCAFE0123, 0);

        drain();
        rr_force = 1'b1; rr_val = 1'b0;
        issue(1, 0, 3'b001, 32'h12, 32'h0, 0, 0, 0);
        k = 0;
        while (!resp_valid && k < 20) begin @(negedge clk); k++; end
        check1("hold_valid_seen", {31'd0, resp_valid}, 32'd1);
        repeat (5) begin
            @(negedge clk);
            check1("hold_req_ready_low", {31'd0, req_ready}, 32'd0);
        end
        rr_val = 1'b1;
        @(posedge clk); #1;
        check1("hold_not_idle_yet", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        check1("hold_idle_after_ready", {31'd0, req_ready}, 32'd1);
        rr_force = 1'b0;

        drain();
        issue(1, 0, 3'b010, 32'h8, 32'h0, 0, 0, 0);
        #1 rst = 1'b1;
        #1;
        check1("rst_wait_busy", {31'd0, busy}, 32'd0);
        check1("rst_wait_ready", {31'd0, req_ready}, 32'd1);
        check1("rst_wait_valid", {31'd0, resp_valid}, 32'd0);
        void'(sb.pop_back());
        repeat (2) @(negedge clk);
        rst = 1'b0;
        issue(1, 0, 3'b010, 32'h8, 32'h0, 0, 0, 0);

        for (int t = 0; t < 300; t++) begin
            k  = $urandom_range(0, 9);
            rd = (k < 4) || (k == 9);
            wr = (k >= 4 && k < 8) || (k == 9);
            if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(0, 7));
            else f3 = {rd ? 1'($urandom) : 1'b0, 2'($urandom_range(0, 2))};
            a  = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2)
                 | 32'($urandom_range(0, 3));
            wd = $urandom;
            issue(rd, wr, f3, a, wd, 0, 0, 0);
        end

        drain();
        repeat (3) @(posedge clk);
        finish_now();
    end

endmodule
